// File: rtl/tnn_pkg.sv
// Shared types and helpers for the ternary threshold neurons:
// weight codes, FSM state type, accumulator sizing and saturating add.
package tnn_pkg;

    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b10;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Result of a clamped addition: value is sign-extended to 32 bits.
    typedef struct packed {
        logic signed [31:0] value;
        logic               sat;
    } sat_res_t;

    // Signed width able to hold +/- max_beats*lanes*(2^in_w-1).
    function automatic int acc_width(input int in_w, input int lanes, input int max_beats);
        return $clog2(max_beats * lanes * ((1 << in_w) - 1) + 1) + 1;
    endfunction

    // a + b clamped to the signed range of 'width' bits; sat flags a clamp.
    function automatic sat_res_t sat_add(input logic signed [31:0] a,
                                         input logic signed [31:0] b,
                                         input int                 width);
        logic signed [32:0] raw;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sat_res_t           res;
        raw       = 33'(a) + 33'(b);
        hi        = (33'sd1 <<< (width - 1)) - 33'sd1;
        lo        = -(33'sd1 <<< (width - 1));
        res.value = raw[31:0];
        res.sat   = 1'b0;
        if (raw > hi) begin
            res.value = hi[31:0];
            res.sat   = 1'b1;
        end else if (raw < lo) begin
            res.value = lo[31:0];
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/tnn_seq_threshold_neuron_if.sv
// Input beat stream and decision stream of one sequential threshold neuron.
interface tnn_seq_threshold_neuron_if
    import tnn_pkg::*;
#(
    parameter int IN_W      = 2,
    parameter int LANES     = 1,
    parameter int MAX_BEATS = 8
);
    localparam int ACC_W = acc_width(IN_W, LANES, MAX_BEATS);

    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*IN_W-1:0]    in_act;
    logic [2*LANES-1:0]       in_wgt;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_bit;
    logic signed [ACC_W-1:0]  out_sum;
    logic                     out_sat;

    // Producer of beats and consumer of decisions.
    modport master (
        output in_valid, in_act, in_wgt, in_last, out_ready,
        input  in_ready, out_valid, out_bit, out_sum, out_sat
    );

    // The neuron itself.
    modport slave (
        input  in_valid, in_act, in_wgt, in_last, out_ready,
        output in_ready, out_valid, out_bit, out_sum, out_sat
    );
endinterface

// File: rtl/tnn_lane_sum.sv
// Combinational signed sum of LANES ternary-weighted unsigned activations.
module tnn_lane_sum
    import tnn_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int LANES = 1,
    parameter int SUM_W = acc_width(IN_W, LANES, 1)
) (
    input  logic [LANES*IN_W-1:0]   act,
    input  logic [2*LANES-1:0]      wgt,
    output logic signed [SUM_W-1:0] sum
);
    logic signed [SUM_W-1:0] term [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [SUM_W-1:0] mag;
            assign mag = SUM_W'({1'b0, act[gi*IN_W +: IN_W]});
            // Codes 00 and 11 both contribute nothing.
            assign term[gi] = (wgt[2*gi +: 2] == W_POS) ? mag :
                              (wgt[2*gi +: 2] == W_NEG) ? -mag : '0;
        end
    endgenerate

    // Adder tree kept as a simple chain; SUM_W already covers the worst case.
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + term[i];
        end
    end
endmodule

// File: rtl/tnn_seq_threshold_neuron.sv
// Sequential ternary threshold neuron: accumulates weighted beats until
// in_last, then holds a (sum + BIAS) > 0 decision until it is consumed.
module tnn_seq_threshold_neuron
    import tnn_pkg::*;
#(
    parameter int IN_W      = 2,
    parameter int LANES     = 1,
    parameter int MAX_BEATS = 8,
    parameter int BIAS      = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    tnn_seq_threshold_neuron_if.slave   bus
);
    localparam int ACC_W  = acc_width(IN_W, LANES, MAX_BEATS);
    localparam int LANE_W = acc_width(IN_W, LANES, 1);

    state_t                   state_reg;
    state_t                   state_next;
    logic                     out_valid_next;
    logic                     in_ready_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic                     sat_reg;
    logic                     out_bit_reg;
    logic signed [ACC_W-1:0]  out_sum_reg;
    logic                     out_sat_reg;

    logic signed [LANE_W-1:0] lane_sum;
    sat_res_t                 acc_res;
    sat_res_t                 bias_res;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  final_sum;
    logic                     beat_fire;
    logic                     out_fire;
    logic                     unused_hi;

    tnn_lane_sum #(
        .IN_W  (IN_W),
        .LANES (LANES),
        .SUM_W (LANE_W)
    ) u_lane_sum (
        .act (bus.in_act),
        .wgt (bus.in_wgt),
        .sum (lane_sum)
    );

    // in_ready_reg is only ever high in ACC, so it qualifies the beat alone.
    assign beat_fire = bus.in_valid && in_ready_reg;
    assign out_fire  = (state_reg == ST_HOLD) && bus.out_ready;

    assign acc_res   = sat_add(32'(acc_reg), 32'(lane_sum), ACC_W);
    assign acc_next  = acc_res.value[ACC_W-1:0];
    assign bias_res  = sat_add(32'(acc_next), BIAS, ACC_W);
    assign final_sum = bias_res.value[ACC_W-1:0];
    // Upper bits are pure sign extension after clamping; the bias clamp is
    // not an accumulator saturation and is not reported.
    assign unused_hi = &{1'b0, acc_res.value[31:ACC_W], bias_res.value[31:ACC_W], bias_res.sat};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_ACC;
        else        state_reg <= state_next;
    end

    // Next state and decision-valid output.
    always_comb begin
        state_next     = state_reg;
        out_valid_next = 1'b0;
        case (state_reg)
            ST_ACC: begin
                if (beat_fire && bus.in_last) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid_next = 1'b1;
                if (bus.out_ready) state_next = ST_ACC;
            end
            default: state_next = ST_ACC;
        endcase
    end

    // Registered ready so it stays low while reset is asserted and rises
    // on the first edge after release; no bubble when leaving HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready_reg <= 1'b0;
        else        in_ready_reg <= (state_next == ST_ACC);
    end

    // Accumulator, sticky saturation and the held decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg     <= '0;
            sat_reg     <= 1'b0;
            out_bit_reg <= 1'b0;
            out_sum_reg <= '0;
            out_sat_reg <= 1'b0;
        end else begin
            if (beat_fire) begin
                if (bus.in_last) begin
                    acc_reg     <= '0;
                    sat_reg     <= 1'b0;
                    out_sum_reg <= final_sum;
                    out_bit_reg <= !final_sum[ACC_W-1] && (final_sum != '0);
                    out_sat_reg <= sat_reg | acc_res.sat;
                end else begin
                    acc_reg     <= acc_next;
                    sat_reg     <= sat_reg | acc_res.sat;
                end
            end
            if (out_fire) out_sat_reg <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_next;
    assign bus.out_bit   = out_bit_reg;
    assign bus.out_sum   = out_sum_reg;
    assign bus.out_sat   = out_sat_reg;
endmodule
